// File: rtl/cdc_bit_synchronizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_bit_synchronizer_if
//  Description : Signal bundle for cdc_bit_synchronizer. It groups the
//                asynchronous input levels with the synchronized levels and
//                the optional edge pulses. The clock and reset stay outside
//                the bundle as plain ports.
//
//  Parameters  :
//      WIDTH     - number of independent bits carried (must match the
//                  WIDTH of the synchronizer instance)
//
//  Signals     :
//      data_in   - asynchronous input levels (driven by the master side)
//      data_out  - synchronized levels, last stage of each chain
//      rise_out  - one-cycle pulse per bit on a 0->1 change of data_out
//      fall_out  - one-cycle pulse per bit on a 1->0 change of data_out
//
//  Modports    :
//      master    - the side that produces data_in and consumes the results
//      slave     - the synchronizer itself
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_bit_synchronizer_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;

    modport master (
        output data_in,
        input  data_out,
        input  rise_out,
        input  fall_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output rise_out,
        output fall_out
    );

endinterface : cdc_bit_synchronizer_if
`default_nettype wire

// File: rtl/cdc_bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_bit_synchronizer
//  Description : Multi-flop synchronizer for asynchronous level signals
//                (buttons, switches, flags from another clock domain).
//                Every bit runs through its own shift chain of
//                SYNC_REG_SIZE flops clocked by clk_in, so a metastable
//                first stage has SYNC_REG_SIZE-1 clock periods to resolve
//                before the value reaches data_out.
//
//                Bits are synchronized independently. A multi-bit word
//                that changes as a whole may show its bits on data_out up
//                to one cycle apart, so this block must not be used for
//                buses that have to stay coherent.
//
//  Parameters  :
//      SYNC_REG_SIZE - flops per chain, legal range 2..8
//      WIDTH         - number of independent bits, >= 1
//      RESET_VALUE   - value loaded into every stage (and the edge history)
//                      while reset is asserted
//
//  Ports       :
//      clk_in        - destination clock, rising edge active
//      rst_n_in      - asynchronous active-low reset
//      sync_if       - slave modport of cdc_bit_synchronizer_if:
//                        data_in  (in)  asynchronous levels
//                        data_out (out) synchronized levels
//                        rise_out (out) 0->1 pulse of data_out
//                        fall_out (out) 1->0 pulse of data_out
//
//  Build macro :
//      SYNC_EDGE_DETECT_EN - when defined, a history register of data_out
//                            is built and rise_out/fall_out carry one-cycle
//                            edge pulses. When undefined, no history
//                            register exists and both pulse outputs are
//                            tied to zero; data_out is unaffected.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_bit_synchronizer #(
    parameter int               SYNC_REG_SIZE = 2,
    parameter int               WIDTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  wire logic                   clk_in,
    input  wire logic                   rst_n_in,
    cdc_bit_synchronizer_if.slave       sync_if
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks. An illegal configuration stops the
    // build rather than silently producing an unsafe synchronizer.
    // ------------------------------------------------------------------------
    if (SYNC_REG_SIZE < 2 || SYNC_REG_SIZE > 8) begin : g_bad_sync_size
        $error("cdc_bit_synchronizer: SYNC_REG_SIZE=%0d outside 2..8",
               SYNC_REG_SIZE);
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("cdc_bit_synchronizer: WIDTH=%0d must be at least 1", WIDTH);
    end

    // ------------------------------------------------------------------------
    // Synchronizer chains, one per bit.
    //
    // Stage 0 is the flop that may go metastable; the last stage drives
    // data_out directly so there is no combinational path from data_in.
    // ASYNC_REG keeps the chain flops packed together and stops the tools
    // from retiming them or folding them into an SRL/shift-register
    // primitive, either of which would destroy the resolution time.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_sync;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        (* ASYNC_REG = "TRUE" *) logic [SYNC_REG_SIZE-1:0] r_chain;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                // Every stage loads the reset value so release never
                // produces a spurious transition at the output.
                r_chain <= {SYNC_REG_SIZE{RESET_VALUE[b]}};
            end else begin
                r_chain <= {r_chain[SYNC_REG_SIZE-2:0], sync_if.data_in[b]};
            end
        end

        assign w_sync[b] = r_chain[SYNC_REG_SIZE-1];
    end : g_bit

    assign sync_if.data_out = w_sync;

    // ------------------------------------------------------------------------
    // Optional edge detection on the synchronized levels.
    //
    // r_prev holds data_out from the previous cycle. Because it resets to
    // the same value as the chains, the first cycle after release compares
    // equal values and no pulse is produced.
    // ------------------------------------------------------------------------
`ifdef SYNC_EDGE_DETECT_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_prev <= RESET_VALUE;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign sync_if.rise_out =  w_sync & ~r_prev;
    assign sync_if.fall_out = ~w_sync &  r_prev;
`else
    assign sync_if.rise_out = {WIDTH{1'b0}};
    assign sync_if.fall_out = {WIDTH{1'b0}};
`endif

endmodule : cdc_bit_synchronizer
`default_nettype wire

// File: tb/tb_cdc_bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_bit_synchronizer
//  Description : Self-checking bench for cdc_bit_synchronizer. Three
//                instances share clock and reset:
//                  u_s2 : SYNC_REG_SIZE=2, WIDTH=1, RESET_VALUE=0
//                  u_s3 : SYNC_REG_SIZE=3, WIDTH=1, RESET_VALUE=0
//                  u_w4 : SYNC_REG_SIZE=2, WIDTH=4, RESET_VALUE=4'b1010
//                Inputs captured at each edge are pushed to a per-instance
//                queue preloaded with SYNC_REG_SIZE-1 reset entries; the
//                entry popped after each edge is the expected data_out.
//                Edge pulses are derived from consecutive expected values.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_bit_synchronizer;

    localparam int         c_S2      = 2;
    localparam int         c_S3      = 3;
    localparam logic [3:0] c_RV4     = 4'b1010;
    localparam int         c_HALF_NS = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic       r_d1 = 1'b0;
    logic [3:0] r_d4 = 4'b0000;

    int n_checks = 0;
    int n_errors = 0;

    always #c_HALF_NS clk = ~clk;

    cdc_bit_synchronizer_if #(.WIDTH(1)) if_s2 ();
    cdc_bit_synchronizer_if #(.WIDTH(1)) if_s3 ();
    cdc_bit_synchronizer_if #(.WIDTH(4)) if_w4 ();

    assign if_s2.data_in = r_d1;
    assign if_s3.data_in = r_d1;
    assign if_w4.data_in = r_d4;

    cdc_bit_synchronizer #(.SYNC_REG_SIZE(c_S2), .WIDTH(1), .RESET_VALUE(1'b0)) u_s2 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .sync_if  (if_s2)
    );

    cdc_bit_synchronizer #(.SYNC_REG_SIZE(c_S3), .WIDTH(1), .RESET_VALUE(1'b0)) u_s3 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .sync_if  (if_s3)
    );

    cdc_bit_synchronizer #(.SYNC_REG_SIZE(c_S2), .WIDTH(4), .RESET_VALUE(c_RV4)) u_w4 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .sync_if  (if_w4)
    );

    // Scoreboard state
    logic       q2[$];
    logic       q3[$];
    logic [3:0] q4[$];
    logic       e2, e3, p2, p3, r2, f2, r3, f3;
    logic [3:0] e4, p4, r4, f4;
    int         rise2_cnt, fall2_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q2.delete(); q3.delete(); q4.delete();
        repeat (c_S2 - 1) q2.push_back(1'b0);
        repeat (c_S3 - 1) q3.push_back(1'b0);
        repeat (c_S2 - 1) q4.push_back(c_RV4);
        e2 = 1'b0; p2 = 1'b0; r2 = 1'b0; f2 = 1'b0;
        e3 = 1'b0; p3 = 1'b0; r3 = 1'b0; f3 = 1'b0;
        e4 = c_RV4; p4 = c_RV4; r4 = 4'b0; f4 = 4'b0;
    endtask

    task automatic compare_all();
        check("s2_data", {31'b0, if_s2.data_out}, {31'b0, e2});
        check("s2_rise", {31'b0, if_s2.rise_out}, {31'b0, r2});
        check("s2_fall", {31'b0, if_s2.fall_out}, {31'b0, f2});
        check("s3_data", {31'b0, if_s3.data_out}, {31'b0, e3});
        check("s3_rise", {31'b0, if_s3.rise_out}, {31'b0, r3});
        check("s3_fall", {31'b0, if_s3.fall_out}, {31'b0, f3});
        check("w4_data", {28'b0, if_w4.data_out}, {28'b0, e4});
        check("w4_rise", {28'b0, if_w4.rise_out}, {28'b0, r4});
        check("w4_fall", {28'b0, if_w4.fall_out}, {28'b0, f4});
    endtask

    // One clock edge: inputs are stable across the edge, so the values read
    // #1 afterwards are the ones the first stage captured.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            q2.push_back(r_d1);
            q3.push_back(r_d1);
            q4.push_back(r_d4);
            e2 = q2.pop_front();
            e3 = q3.pop_front();
            e4 = q4.pop_front();
`ifdef SYNC_EDGE_DETECT_EN
            r2 = e2 & ~p2;  f2 = ~e2 & p2;
            r3 = e3 & ~p3;  f3 = ~e3 & p3;
            r4 = e4 & ~p4;  f4 = ~e4 & p4;
`else
            r2 = 1'b0; f2 = 1'b0; r3 = 1'b0; f3 = 1'b0;
            r4 = 4'b0; f4 = 4'b0;
`endif
            p2 = e2; p3 = e3; p4 = e4;
        end
        if (if_s2.rise_out === 1'b1) rise2_cnt++;
        if (if_s2.fall_out === 1'b1) fall2_cnt++;
        compare_all();
    endtask

    // Assert reset between edges and check outputs without any clock edge.
    task automatic async_reset();
        #4;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic release_reset();
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rise2_cnt = 0;
        fall2_cnt = 0;

        // Reset held with inputs high and the clock running.
        r_d1 = 1'b1;
        r_d4 = 4'b0101;
        #1 rst_n = 1'b0;
        #1 compare_all();
        repeat (3) tick();
        check("reset_hold_s2", {31'b0, if_s2.data_out}, 32'd0);
        check("reset_hold_w4", {28'b0, if_w4.data_out}, {28'b0, c_RV4});

        // Release with inputs low; then latency of a single 0->1 step.
        r_d1 = 1'b0;
        r_d4 = c_RV4;
        release_reset();
        repeat (3) tick();
        r_d1 = 1'b1;
        r_d4 = 4'b0101;
        repeat (4) tick();

        // Edge pulses: rise, hold, fall.
        r_d1 = 1'b0;
        repeat (4) tick();
        rise2_cnt = 0;
        fall2_cnt = 0;
        r_d1 = 1'b1;
        repeat (5) tick();
        r_d1 = 1'b0;
        repeat (5) tick();
`ifdef SYNC_EDGE_DETECT_EN
        check("s2_rise_count", rise2_cnt, 1);
        check("s2_fall_count", fall2_cnt, 1);
`else
        check("s2_rise_count", rise2_cnt, 0);
        check("s2_fall_count", fall2_cnt, 0);
`endif

        // Narrow one-cycle pulse.
        r_d1 = 1'b1;
        r_d4 = 4'b1111;
        tick();
        r_d1 = 1'b0;
        r_d4 = 4'b0000;
        repeat (5) tick();

        // Mid-flight reset: value in the chain must be discarded.
        r_d1 = 1'b1;
        r_d4 = 4'b0101;
        tick();
        async_reset();
        r_d1 = 1'b0;
        r_d4 = c_RV4;
        repeat (3) tick();
        release_reset();
        repeat (4) tick();

        // Random levels, inputs held at least one cycle.
        repeat (40) begin
            r_d1 = 1'($urandom_range(0, 1));
            r_d4 = 4'($urandom_range(0, 15));
            tick();
        end

        // Async reset with non-reset contents in the chains.
        r_d1 = 1'b1;
        r_d4 = 4'b0101;
        repeat (4) tick();
        async_reset();
        release_reset();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_cdc_bit_synchronizer
`default_nettype wire
